// File: rtl/stage_reg_pkg.sv
// stage_reg_pkg: shared pipeline defines, payload field widths and stage status encodings
package stage_reg_pkg;
    localparam logic STOP       = 1'b1;
    localparam logic NO_STOP    = 1'b0;
    localparam logic RST_ENABLE = 1'b1;
    localparam logic [31:0] ZERO_WORD = 32'h0;
    localparam int WD_W    = 5;
    localparam int WREG_W  = 1;
    localparam int WORD_W  = 32;
    localparam int WHILO_W = 1;
    localparam int CNT_W   = 2;
    localparam int DW_DEF  = WD_W + WREG_W + 3 * WORD_W + WHILO_W;
    localparam int CW_DEF  = 2 * WORD_W + CNT_W;
    localparam int HOLD_W  = 8;
    localparam int PERF_W  = 32;
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_HELD  = 2'd2
    } state_t;
endpackage

// File: rtl/stage_reg_if.sv
// stage_reg_if: control, payload, carry and status bundle of one pipeline stage register
interface stage_reg_if
    import stage_reg_pkg::*;
#(
    parameter int STALLW = 6,
    parameter int DW     = DW_DEF,
    parameter int CW     = CW_DEF
) ();
    logic [STALLW-1:0] stall;
    logic              flush;
    logic              in_valid;
    logic [DW-1:0]     in_data;
    logic [CW-1:0]     carry_i;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [CW-1:0]     carry_o;
    logic [HOLD_W-1:0] hold_cnt;
    logic [PERF_W-1:0] stall_cycles;
    logic [PERF_W-1:0] bubble_count;

    modport master (
        output stall, flush, in_valid, in_data, carry_i,
        input  out_valid, out_data, carry_o, hold_cnt, stall_cycles, bubble_count
    );

    modport slave (
        input  stall, flush, in_valid, in_data, carry_i,
        output out_valid, out_data, carry_o, hold_cnt, stall_cycles, bubble_count
    );
endinterface

// File: rtl/stage_reg_perf_cnt.sv
// stage_perf_cnt: wrapping counters of stalled cycles and inserted bubbles
module stage_perf_cnt
    import stage_reg_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_hit,
    input  logic              bubble_hit,
    output logic [PERF_W-1:0] stall_cycles,
    output logic [PERF_W-1:0] bubble_count
);
    // count every stalled cycle and every bubble, wrapping naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            stall_cycles <= ZERO_WORD;
            bubble_count <= ZERO_WORD;
        end else begin
            stall_cycles <= stall_cycles + PERF_W'(stall_hit);
            bubble_count <= bubble_count + PERF_W'(bubble_hit);
        end
    end
endmodule

// File: rtl/stage_reg.sv
// stage_reg: pipeline stage register with flush/bubble/advance/hold and multi-cycle carry; STAGE_REG_PERF_EN adds perf counters
module stage_reg
    import stage_reg_pkg::*;
#(
    parameter int STAGE  = 3,
    parameter int STALLW = 6,
    parameter int DW     = DW_DEF,
    parameter int CW     = CW_DEF
) (
    input logic        clk,
    input logic        rst,
    stage_reg_if.slave bus
);
    logic              stop_here;
    logic              stop_next;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [CW-1:0]     carry_o;
    logic [HOLD_W-1:0] hold_cnt;
    state_t            state;

    assign stop_here = bus.stall[STAGE] == STOP;
    assign stop_next = bus.stall[STAGE+1] == STOP;

    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.carry_o   = carry_o;
    assign bus.hold_cnt  = hold_cnt;

    // one action per edge in priority flush, bubble, advance, hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            carry_o   <= '0;
            hold_cnt  <= '0;
            state     <= ST_EMPTY;
        end else if (bus.flush) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            carry_o   <= '0;
            hold_cnt  <= '0;
            state     <= ST_EMPTY;
        end else if (stop_here && stop_next == NO_STOP) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            carry_o   <= bus.carry_i;
            hold_cnt  <= '0;
            state     <= ST_EMPTY;
        end else if (!stop_here) begin
            out_valid <= bus.in_valid;
            out_data  <= bus.in_valid ? bus.in_data : '0;
            carry_o   <= '0;
            hold_cnt  <= '0;
            state     <= bus.in_valid ? ST_FULL : ST_EMPTY;
        end else begin
            carry_o   <= bus.carry_i;
            hold_cnt  <= (hold_cnt == '1) ? hold_cnt : hold_cnt + 8'd1;
            state     <= (state == ST_EMPTY) ? ST_EMPTY : ST_HELD;
        end
    end

`ifdef STAGE_REG_PERF_EN
    logic bubble;

    assign bubble = !bus.flush && stop_here && !stop_next;

    stage_perf_cnt u_perf (
        .clk          (clk),
        .rst          (rst),
        .stall_hit    (stop_here),
        .bubble_hit   (bubble),
        .stall_cycles (bus.stall_cycles),
        .bubble_count (bus.bubble_count)
    );
`else
    assign bus.stall_cycles = '0;
    assign bus.bubble_count = '0;
`endif
endmodule

// File: doc/stage_reg.md
STAGE_REG -- requirements
Module: stage_reg

Interface
- REQ-001: Parameter STAGE, default 3: index of this register's stage in the stall vector; legal range 0..STALLW-2.
- REQ-002: Parameter STALLW, default 6: width of the stall vector.
- REQ-003: Parameter DW, default 103: payload width (wd 5 + wreg 1 + wdata 32 + hi 32 + lo 32 + whilo 1).
- REQ-004: Parameter CW, default 66: carry width (hilo 64 + cnt 2).
- REQ-005: clk  in  1  single clock; all state updates on posedge.
- REQ-006: rst  in  1  asynchronous, active-high reset.
- REQ-007: stall  in  STALLW  per-stage stop flags from the control block; 1 = Stop.
- REQ-008: flush  in  1  synchronous pipeline flush, e.g. on an exception.
- REQ-009: in_valid  in  1  upstream payload valid.
- REQ-010: in_data  in  DW  upstream payload.
- REQ-011: carry_i  in  CW  multi-cycle intermediate state from the upstream stage.
- REQ-012: out_valid  out  1  registered payload valid.
- REQ-013: out_data  out  DW  registered payload.
- REQ-014: carry_o  out  CW  carry returned to the upstream stage.
- REQ-015: hold_cnt  out  8  consecutive hold cycles, saturating.
- REQ-016: stall_cycles  out  32  performance counter; see Configuration.
- REQ-017: bubble_count  out  32  performance counter; see Configuration.

Function
- REQ-018: On each posedge, exactly one action SHALL apply, in this priority: flush, bubble, advance, hold.
- REQ-019: Flush (flush=1) SHALL clear out_valid, out_data, carry_o and hold_cnt to 0, regardless of stall.
- REQ-020: Bubble (stall[STAGE]=1 and stall[STAGE+1]=0) SHALL clear out_valid and out_data to 0, load carry_o from carry_i, and clear hold_cnt.
- REQ-021: Advance (stall[STAGE]=0) SHALL load out_valid from in_valid and out_data from in_data when in_valid=1, or from 0 when in_valid=0; it SHALL clear carry_o and hold_cnt.
- REQ-022: Hold (stall[STAGE]=1 and stall[STAGE+1]=1) SHALL keep out_valid and out_data unchanged, load carry_o from carry_i, and increment hold_cnt, saturating at 255.
- REQ-023: Latency SHALL be one cycle from input to output under advance.
- REQ-024: out_data SHALL be all-zero whenever out_valid=0.
- REQ-025: Three-state status FSM, internal:
  - EMPTY: out_valid=0.
  - FULL: payload loaded this cycle.
  - HELD: payload retained for 1 or more cycles.
- REQ-026: FSM transitions:
  - advance with in_valid=1 -> FULL.
  - advance with in_valid=0 -> EMPTY.
  - hold from FULL or HELD -> HELD.
  - hold from EMPTY -> EMPTY.
  - flush or bubble -> EMPTY.
- REQ-027: Simultaneous flush and stall SHALL resolve as flush.

Reset
- REQ-028: rst=1 SHALL asynchronously force the following to 0 within the same cycle: out_valid, out_data, carry_o, hold_cnt, stall_cycles, bubble_count; the FSM SHALL be forced to EMPTY.
- REQ-029: Reset asserted mid-hold SHALL discard the held payload and carry; the first posedge after release SHALL act per REQ-018.

Configuration
- REQ-030: Macro STAGE_REG_PERF_EN defined:
  - stall_cycles SHALL increment on every non-reset cycle with stall[STAGE]=1.
  - bubble_count SHALL increment on every bubble action.
  - Both counters SHALL wrap modulo 2^32.
- REQ-031: Macro STAGE_REG_PERF_EN undefined: stall_cycles and bubble_count SHALL be constant 0, with no counter flops; ports are still present.

Structure
- REQ-032: Stop/NoStop, RstEnable, ZeroWord, payload field widths, default DW/CW and FSM state encodings SHALL live in the shared defines package.
- REQ-033: The performance counters SHALL be one sub-module, stage_perf_cnt, instantiated only under STAGE_REG_PERF_EN.

Verification
- REQ-034: Reset release, then advance with in_valid=1 and in_data=0x...A5 -> next cycle out_valid=1, out_data=0x...A5, carry_o=0.
- REQ-035: stall=6'b001111, STAGE=3, carry_i=66'h3_0000_0001_0000_0002 -> out_valid=0, out_data=0, carry_o equals carry_i, bubble_count +1.
- REQ-036: stall=6'b011111 for 300 cycles with a valid payload held -> out_data unchanged, hold_cnt=255, stall_cycles=300.
- REQ-037: flush=1 together with stall=6'b011111 -> out_valid=0, carry_o=0, hold_cnt=0.
- REQ-038: rst asserted mid-hold -> all outputs 0 before the next posedge; first advance after release loads normally.
